// File: rtl/hq_time_deserializer_pkg.sv
// Shared constants and types for the HAVE QUICK time nibble receiver:
// frame layout, slot indices, FSM state type and BCD limits.
package hq_time_pkg;

   localparam int NIBBLES_PER_FRAME = 11;

   localparam int SLOT_HH_M = 0;
   localparam int SLOT_HH_S = 1;
   localparam int SLOT_MM_M = 2;
   localparam int SLOT_MM_S = 3;
   localparam int SLOT_SS_M = 4;
   localparam int SLOT_SS_S = 5;
   localparam int SLOT_DOY_H = 6;
   localparam int SLOT_DOY_T = 7;
   localparam int SLOT_DOY_U = 8;
   localparam int SLOT_YY_M = 9;
   localparam int SLOT_YY_S = 10;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      CHECK
   } state_t;

   localparam logic [7:0] HH_MAX = 8'h23;
   localparam logic [7:0] MM_MAX = 8'h59;
   localparam logic [7:0] SS_MAX = 8'h59;
   localparam logic [11:0] DOY_MIN = 12'h001;
   localparam logic [11:0] DOY_MAX = 12'h366;

   function automatic logic is_bcd(input logic [3:0] n);
      return n <= 4'd9;
   endfunction

endpackage

// File: rtl/hq_time_deserializer_if.sv
// Nibble link handshake: nib/nib_valid/nib_sof forward, nib_ready back.
// master = nibble source, slave = receiver.
interface hq_nib_if;
   logic [3:0] nib;
   logic nib_valid;
   logic nib_sof;
   logic nib_ready;

   modport master (
      output nib, nib_valid, nib_sof,
      input nib_ready
   );

   modport slave (
      input nib, nib_valid, nib_sof,
      output nib_ready
   );
endinterface

// File: rtl/hq_time_deserializer_bcd_checker.sv
// Combinational range check of an assembled time frame.
// In: hh, mm, ss, doy, yy (BCD). Out: ok = every digit and field legal.
module hq_bcd_checker
   import hq_time_pkg::*;
(
   input logic [7:0] hh,
   input logic [7:0] mm,
   input logic [7:0] ss,
   input logic [11:0] doy,
   input logic [7:0] yy,
   output logic ok
);

   logic digits_ok;

   assign digits_ok =
      is_bcd(hh[7:4]) && is_bcd(hh[3:0]) &&
      is_bcd(mm[7:4]) && is_bcd(mm[3:0]) &&
      is_bcd(ss[7:4]) && is_bcd(ss[3:0]) &&
      is_bcd(doy[11:8]) && is_bcd(doy[7:4]) &&
      is_bcd(doy[3:0]) &&
      is_bcd(yy[7:4]) && is_bcd(yy[3:0]);

   assign ok = digits_ok &&
      (hh <= HH_MAX) && (mm <= MM_MAX) &&
      (ss <= SS_MAX) &&
      (doy >= DOY_MIN) && (doy <= DOY_MAX);

endmodule

// File: rtl/hq_time_deserializer.sv
// Reassembles the 11-nibble BCD time frame into a registered time word.
// Ports: clk, rst_n (async low), link (hq_nib_if.slave), hh/mm/ss/doy/yy,
// time_valid and frame_err pulses, frame_cnt. Macro HQ_BCD_CHECK_EN adds
// BCD range qualification of each frame.
module hq_time_deserializer
   import hq_time_pkg::*;
#(
   parameter int GAP_TIMEOUT = 64,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic rst_n,
   hq_nib_if.slave link,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic [11:0] doy,
   output logic [7:0] yy,
   output logic time_valid,
   output logic frame_err,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
   localparam logic [3:0] LAST = 4'(SLOT_YY_S);

   state_t state;
   logic [3:0] idx;
   logic [GAP_W-1:0] gap;
   logic ready_q;
   // slot 10 is never stored: the verdict uses the live nibble
   logic [3:0] slot [0:NIBBLES_PER_FRAME-2];

   logic xfer;
   logic ok;
   logic [7:0] f_hh, f_mm, f_ss, f_yy;
   logic [11:0] f_doy;

   assign link.nib_ready = ready_q;
   assign xfer = link.nib_valid & ready_q;

   assign f_hh = {slot[SLOT_HH_M], slot[SLOT_HH_S]};
   assign f_mm = {slot[SLOT_MM_M], slot[SLOT_MM_S]};
   assign f_ss = {slot[SLOT_SS_M], slot[SLOT_SS_S]};
   assign f_doy = {slot[SLOT_DOY_H], slot[SLOT_DOY_T],
                   slot[SLOT_DOY_U]};
   assign f_yy = {slot[SLOT_YY_M], link.nib};

`ifdef HQ_BCD_CHECK_EN
   hq_bcd_checker u_chk (
      .hh (f_hh),
      .mm (f_mm),
      .ss (f_ss),
      .doy(f_doy),
      .yy (f_yy),
      .ok (ok)
   );
`else
   assign ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx <= '0;
         gap <= '0;
         ready_q <= 1'b1;
         hh <= '0;
         mm <= '0;
         ss <= '0;
         doy <= '0;
         yy <= '0;
         time_valid <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
         for (int i = 0; i < NIBBLES_PER_FRAME - 1; i++)
            slot[i] <= '0;
      end else begin
         time_valid <= 1'b0;
         frame_err <= 1'b0;
         ready_q <= 1'b1;
         unique case (state)
            IDLE: begin
               if (xfer && link.nib_sof) begin
                  slot[SLOT_HH_M] <= link.nib;
                  idx <= 4'd1;
                  gap <= '0;
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               if (xfer) begin
                  gap <= '0;
                  if (link.nib_sof) begin
                     // restart on this nibble
                     frame_err <= 1'b1;
                     slot[SLOT_HH_M] <= link.nib;
                     idx <= 4'd1;
                  end else if (idx == LAST) begin
                     idx <= '0;
                     ready_q <= 1'b0;
                     state <= CHECK;
                     if (ok) begin
                        hh <= f_hh;
                        mm <= f_mm;
                        ss <= f_ss;
                        doy <= f_doy;
                        yy <= f_yy;
                        time_valid <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     slot[idx] <= link.nib;
                     idx <= idx + 4'd1;
                  end
               end else if (gap == GAP_W'(GAP_TIMEOUT - 1)) begin
                  frame_err <= 1'b1;
                  idx <= '0;
                  gap <= '0;
                  state <= IDLE;
               end else begin
                  gap <= gap + 1'b1;
               end
            end
            CHECK: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hq_time_deserializer.sv
// Scoreboard bench for hq_time_deserializer (CNT_W=4 so the wrap is short).
// Build with +define+HQ_BCD_CHECK_EN to exercise the BCD qualification.
module tb_hq_time_deserializer;

   localparam int CNT_W = 4;
   localparam int GAP = 64;

   typedef struct {
      logic err;
      logic [7:0] hh, mm, ss;
      logic [11:0] doy;
      logic [7:0] yy;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [7:0] hh, mm, ss, yy;
   logic [11:0] doy;
   logic time_valid, frame_err;
   logic [CNT_W-1:0] frame_cnt;

   hq_nib_if nif ();

   hq_time_deserializer #(
      .GAP_TIMEOUT(GAP),
      .CNT_W(CNT_W)
   ) dut (
      .clk (clk),
      .rst_n (rst_n),
      .link (nif),
      .hh (hh),
      .mm (mm),
      .ss (ss),
      .doy (doy),
      .yy (yy),
      .time_valid(time_valid),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   exp_t expq[$];
   exp_t hold;
   logic [CNT_W-1:0] exp_cnt;

   localparam logic [43:0] F1 = 44'h12345912324;

   function automatic logic bcd_ok(input logic [43:0] f);
      logic r;
      r = 1'b1;
      for (int i = 0; i < 11; i++)
         if (f[4*i +: 4] > 4'd9) r = 1'b0;
      if (f[43:36] > 8'h23) r = 1'b0;
      if (f[35:28] > 8'h59) r = 1'b0;
      if (f[27:20] > 8'h59) r = 1'b0;
      if (f[19:8] < 12'h001 || f[19:8] > 12'h366) r = 1'b0;
      return r;
   endfunction

   task automatic clear_model();
      hold.err = 1'b0;
      hold.hh = '0;
      hold.mm = '0;
      hold.ss = '0;
      hold.doy = '0;
      hold.yy = '0;
      hold.cnt = '0;
      exp_cnt = '0;
      expq.delete();
   endtask

   // Advance one cycle; pop the scoreboard on every pulse and
   // confirm the held time word matches the last expected good frame.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (time_valid || frame_err) begin
         total++;
         if (expq.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: tv=%b fe=%b, none expected",
                     time_valid, frame_err);
         end else begin
            e = expq.pop_front();
            if (!e.err) hold = e;
            if ({time_valid, frame_err} !== {~e.err, e.err}) begin
               bad++;
               $display("FAIL sb_kind: tv=%b fe=%b, want tv=%b fe=%b",
                        time_valid, frame_err, ~e.err, e.err);
            end
         end
      end
      total++;
      if ({hh, mm, ss, doy, yy, frame_cnt} !==
          {hold.hh, hold.mm, hold.ss, hold.doy, hold.yy, hold.cnt}) begin
         bad++;
         $display("FAIL sb_word: got %h %h %h %h %h cnt=%0d, want %h %h %h %h %h cnt=%0d",
                  hh, mm, ss, doy, yy, frame_cnt,
                  hold.hh, hold.mm, hold.ss, hold.doy, hold.yy, hold.cnt);
      end
   endtask

   task automatic send(input logic [3:0] n, input logic s);
      int b;
      nif.nib = n;
      nif.nib_sof = s;
      nif.nib_valid = 1'b1;
      b = 0;
      while (nif.nib_ready !== 1'b1 && b < 20) begin
         tick();
         b++;
      end
      total++;
      if (b >= 20) begin
         bad++;
         $display("FAIL ready_wait: nib_ready=%b after %0d cycles, want 1",
                  nif.nib_ready, b);
      end
      tick();
      nif.nib_valid = 1'b0;
      nif.nib_sof = 1'b0;
   endtask

   task automatic push_verdict(input logic [43:0] f);
      exp_t e;
      logic good;
`ifdef HQ_BCD_CHECK_EN
      good = bcd_ok(f);
`else
      good = 1'b1;
`endif
      e.err = ~good;
      e.hh = f[43:36];
      e.mm = f[35:28];
      e.ss = f[27:20];
      e.doy = f[19:8];
      e.yy = f[7:0];
      if (good) exp_cnt = exp_cnt + 1'b1;
      e.cnt = exp_cnt;
      expq.push_back(e);
   endtask

   task automatic send_frame(input logic [43:0] f, input int idle);
      for (int i = 0; i < 11; i++) begin
         repeat (idle) tick();
         if (i == 10) push_verdict(f);
         send(f[43-4*i -: 4], i == 0);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_model();
      repeat (3) tick();
      total++;
      if (nif.nib_ready !== 1'b1 || time_valid !== 1'b0 ||
          frame_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctl: ready=%b tv=%b fe=%b, want 1 0 0",
                  nif.nib_ready, time_valid, frame_err);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      send_frame(F1, 0);
      total++;
      if (nif.nib_ready !== 1'b0) begin
         bad++;
         $display("FAIL basic_check_ready: nib_ready=%b, want 0",
                  nif.nib_ready);
      end
      total++;
      if ({hh, mm, ss, doy, yy} !== 44'h12345912324 ||
          frame_cnt !== 4'd1) begin
         bad++;
         $display("FAIL basic_word: got %h %h %h %h %h cnt=%0d, want 12 34 59 123 24 cnt=1",
                  hh, mm, ss, doy, yy, frame_cnt);
      end
      tick();
   endtask

   task automatic test_gapped();
      send_frame(44'h21103506625, 9);
      tick();
      total++;
      if (frame_cnt !== 4'd2) begin
         bad++;
         $display("FAIL gapped_cnt: frame_cnt=%0d, want 2", frame_cnt);
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      for (int i = 0; i < 5; i++)
         send(F1[43-4*i -: 4], i == 0);
      e = hold;
      e.err = 1'b1;
      expq.push_back(e);
      repeat (GAP + 20) tick();
      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL timeout_err: %0d pulses pending, want 0",
                  expq.size());
      end
      total++;
      if (frame_cnt !== exp_cnt) begin
         bad++;
         $display("FAIL timeout_cnt: frame_cnt=%0d, want %0d",
                  frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_sof_restart();
      exp_t e;
      for (int i = 0; i < 7; i++)
         send(F1[43-4*i -: 4], i == 0);
      e = hold;
      e.err = 1'b1;
      expq.push_back(e);
      send_frame(44'h07150811999, 0);
      tick();
      total++;
      if (expq.size() != 0 || frame_cnt !== exp_cnt) begin
         bad++;
         $display("FAIL restart: pending=%0d cnt=%0d, want 0 cnt=%0d",
                  expq.size(), frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_idle_nosof();
      for (int i = 0; i < 5; i++)
         send(4'(i + 3), 1'b0);
      repeat (3) tick();
      total++;
      if (frame_cnt !== exp_cnt) begin
         bad++;
         $display("FAIL idle_nosof: frame_cnt=%0d, want %0d",
                  frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 6; i++)
         send(F1[43-4*i -: 4], i == 0);
      rst_n = 1'b0;
      clear_model();
      tick();
      total++;
      if ({hh, mm, ss, doy, yy} !== 44'h0 || frame_cnt !== '0 ||
          nif.nib_ready !== 1'b1) begin
         bad++;
         $display("FAIL midreset: word=%h cnt=%0d ready=%b, want 0 0 1",
                  {hh, mm, ss, doy, yy}, frame_cnt, nif.nib_ready);
      end
      rst_n = 1'b1;
      tick();
      send_frame(44'h23595936599, 0);
      tick();
      total++;
      if (frame_cnt !== 4'd1 || hh !== 8'h23) begin
         bad++;
         $display("FAIL after_reset: cnt=%0d hh=%h, want 1 23",
                  frame_cnt, hh);
      end
   endtask

   task automatic test_bcd();
      logic [43:0] fr [3];
      fr[0] = 44'h24345912324;
      fr[1] = 44'h12345900024;
      fr[2] = 44'h1234591232A;
      for (int k = 0; k < 3; k++) begin
         send_frame(fr[k], 0);
         tick();
         total++;
         if (frame_cnt !== exp_cnt || expq.size() != 0) begin
            bad++;
            $display("FAIL bcd_%0d: cnt=%0d pending=%0d, want cnt=%0d 0",
                     k, frame_cnt, expq.size(), exp_cnt);
         end
      end
   endtask

   task automatic test_back_to_back_wrap();
      logic [43:0] f;
      rst_n = 1'b0;
      clear_model();
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
         f = F1;
         f[35:28] = {4'd0, 4'(i / 10)};
         f[27:20] = {4'd5, 4'(i % 10)};
         send_frame(f, 0);
      end
      tick();
      total++;
      if (frame_cnt !== 4'd1) begin
         bad++;
         $display("FAIL wrap: frame_cnt=%0d, want 1", frame_cnt);
      end
   endtask

   initial begin
      nif.nib = '0;
      nif.nib_valid = 1'b0;
      nif.nib_sof = 1'b0;
      test_reset();
      test_basic();
      test_gapped();
      test_timeout();
      test_sof_restart();
      test_idle_nosof();
      test_reset_midframe();
      test_bcd();
      test_back_to_back_wrap();
      repeat (3) tick();
      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: %0d pending, want 0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
